// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, FSM states and default width
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational ALU datapath; ALU_FAST_SHIFT_EN adds the barrel shifter
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

`ifdef ALU_FAST_SHIFT_EN
  logic [SHAMT_W-1:0] shamt;
  assign shamt = op_b[SHAMT_W-1:0];
`endif

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_ADD:  result = op_a + op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  result = op_a << shamt;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
`else
      // Only reached with shamt == 0; non-zero shifts go through the iterator.
      ALU_SLL, ALU_SRL, ALU_SRA: result = op_a;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - EX-stage ALU with handshake FSM; ALU_FAST_SHIFT_EN selects single-cycle shifts
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_t          state;
  logic [XLEN-1:0] c_result;
  logic            c_illegal;

  alu_comb #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_comb (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (c_result),
    .illegal  (c_illegal)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0]    work;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         kind;
  logic [XLEN-1:0]    shifted;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = op_b[SHAMT_W-1:0];

  always_comb begin
    shifted = work;
    case (kind)
      ALU_SLL: shifted = {work[XLEN-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, work[XLEN-1:1]};
      default: shifted = {work[XLEN-1], work[XLEN-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      work    <= '0;
      cnt     <= '0;
      kind    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
            if (is_shift(alu_ctrl) && (shamt != '0)) begin
              work  <= op_a;
              cnt   <= shamt;
              kind  <= alu_ctrl;
              state <= SHIFT;
            end else
`endif
            begin
              result  <= c_result;
              zero    <= (c_result == '0);
              illegal <= c_illegal;
              state   <= DONE;
            end
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        // The last step writes the result directly so latency is shamt+1.
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            result  <= shifted;
            zero    <= (shifted == '0);
            illegal <= 1'b0;
            state   <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec against a behavioural ALU model
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_result;
  logic        exp_illegal;
  bit          exp_armed = 1'b0;
  logic [31:0] last_result;
  logic        last_zero;
  logic        last_illegal;

  alu_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {illegal, result} straight from the instruction-set rules.
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic [31:0] fill;
    sh = int'(b[4:0]);
    fill = ~(32'hFFFF_FFFF >> sh);
    case (c)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0011: return {1'b0, a ^ b};
      4'b0100: return {1'b0, 32'(($signed(a) < $signed(b)) ? 1 : 0)};
      4'b0101: return {1'b0, 32'((a < b) ? 1 : 0)};
      4'b0110: return {1'b0, a - b};
      4'b0111: return {1'b0, a << sh};
      4'b1000: return {1'b0, a >> sh};
      4'b1010: return {1'b0, (a >> sh) | (a[31] ? fill : 32'h0)};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return (c == 4'hF && b == 32'hFFFF_FFFF) ? 1 : 1;
`else
    if ((c == 4'b0111 || c == 4'b1000 || c == 4'b1010) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && exp_armed) begin
      check("result", {32'h0, result}, {32'h0, exp_result});
      check("zero", {63'h0, zero}, {63'h0, (exp_result == 32'h0)});
      check("illegal", {63'h0, illegal}, {63'h0, exp_illegal});
      check("in_ready_busy", {63'h0, in_ready}, 64'h0);
    end
  end

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit early);
    logic [32:0] m;
    int cyc;
    bit seen;
    @(negedge clk);
    m = model(c, a, b);
    exp_result  = m[31:0];
    exp_illegal = m[32];
    exp_armed   = 1'b1;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = early;
    check("in_ready_idle", {63'h0, in_ready}, 64'h1);
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      op_a     = $urandom;
      op_b     = $urandom;
      alu_ctrl = 4'($urandom);
      if (out_valid) seen = 1'b1;
    end
    check("out_valid_seen", {63'h0, seen}, 64'h1);
    check("latency", 64'(cyc), 64'(exp_lat(c, b)));
    last_result  = result;
    last_zero    = zero;
    last_illegal = illegal;
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        check("held_valid", {63'h0, out_valid}, 64'h1);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", {63'h0, out_valid}, 64'h0);
    check("in_ready_back", {63'h0, in_ready}, 64'h1);
    out_ready = 1'b0;
    exp_armed = 1'b0;
  endtask

  initial begin
    int seen_valid;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check("rst_result", {32'h0, result}, 64'h0);
    check("rst_zero", {63'h0, zero}, 64'h0);
    check("rst_illegal", {63'h0, illegal}, 64'h0);

    check("model_add", 64'(model(4'b0010, 32'd5, 32'd7)), 64'h0_0000_000C);
    check("model_sra", 64'(model(4'b1010, 32'h8000_0000, 32'd4)), 64'h0_F800_0000);
    check("model_slt", 64'(model(4'b0100, 32'hFFFF_FFFF, 32'd1)), 64'h0_0000_0001);
    check("model_sltu", 64'(model(4'b0101, 32'hFFFF_FFFF, 32'd1)), 64'h0_0000_0000);
    check("model_bad", 64'(model(4'b1111, 32'h1, 32'h2)), 64'h1_0000_0000);

    run_op(4'b0010, 32'd5, 32'd7, 0, 1'b0);
    check("add_lit", {32'h0, last_result}, 64'd12);
    check("add_zero", {63'h0, last_zero}, 64'h0);

    run_op(4'b0110, 32'h1234, 32'h1234, 0, 1'b0);
    check("sub_zero", {63'h0, last_zero}, 64'h1);
    run_op(4'b0110, 32'h0, 32'h1, 0, 1'b0);
    check("sub_wrap", {32'h0, last_result}, 64'hFFFF_FFFF);

    run_op(4'b0100, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
    check("slt_lit", {32'h0, last_result}, 64'h1);
    run_op(4'b0101, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
    check("sltu_lit", {32'h0, last_result}, 64'h0);

    run_op(4'b1010, 32'h8000_0000, 32'd4, 0, 1'b0);
    check("sra_lit", {32'h0, last_result}, 64'hF800_0000);
    run_op(4'b1010, 32'h8000_0000, 32'd0, 0, 1'b0);
    check("sra_zero_amt", {32'h0, last_result}, 64'h8000_0000);
    run_op(4'b1000, 32'h0000_00F0, 32'h0000_0104, 0, 1'b0);
    check("srl_upper_ignored", {32'h0, last_result}, 64'hF);

    run_op(4'b0111, 32'h0000_0003, 32'd31, 0, 1'b1);
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1'b1);
    run_op(4'b0001, 32'hA000_0000, 32'h0000_0005, 0, 1'b0);
    run_op(4'b0011, 32'hDEAD_BEEF, 32'hFFFF_0000, 10, 1'b0);

    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
    check("illegal_flag", {63'h0, last_illegal}, 64'h1);
    check("illegal_result", {32'h0, last_result}, 64'h0);
    run_op(4'b1001, 32'h1, 32'h1, 2, 1'b0);

    @(negedge clk);
    alu_ctrl = 4'b0111;
    op_a     = 32'h1;
    op_b     = 32'd20;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {63'h0, in_ready}, 64'h1);
    seen_valid = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("abort_no_output", 64'(seen_valid), 64'h0);

    run_op(4'b0010, 32'hFFFF_FFFF, 32'h2, 0, 1'b0);
    check("add_after_abort", {32'h0, last_result}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
